// File: rtl/sysid_check_ctrl_if.sv
// ---------------------------------------------------------------------------
// sysid_check_ctrl_if
//   Avalon-MM read-only bus between the boot-time ID checker (master) and the
//   32-bit system-ID slave.
//
//   Signals
//     av_address      master -> slave  word address (0 = system ID, 1 = timestamp)
//     av_read         master -> slave  read strobe
//     av_waitrequest  slave  -> master stall
//     av_readdata     slave  -> master 32-bit read data
//
//   Handshake: av_read acts as "valid" and !av_waitrequest as "ready". A read
//   is accepted on a rising clock edge where av_read=1 and av_waitrequest=0.
//   While av_waitrequest=1 the master holds av_read and av_address unchanged.
//   There is no readdatavalid; readdata is sampled a fixed number of cycles
//   after the accept (the master's READ_LATENCY).
// ---------------------------------------------------------------------------
interface sysid_check_ctrl_if;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_read,
    input  av_waitrequest,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_read,
    output av_waitrequest,
    output av_readdata
  );
endinterface

// File: rtl/sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// sysid_check_ctrl
//   Boot-time controller that reads the system-ID slave (address 0: system ID,
//   address 1: build timestamp), compares both words against build-time
//   expectations and reports pass/fail, the captured words and a stall
//   timeout. Software start is gated on 'pass'.
//
//   Ports
//     clock      in   system clock, rising edge
//     reset      in   asynchronous active-high reset
//     start      in   single-cycle request to (re)run the check sequence
//     av         master modport of sysid_check_ctrl_if (Avalon-MM read port)
//     busy       out  sequence in progress (RD_ID/WAIT_ID/RD_TS/WAIT_TS)
//     done       out  sequence finished; held until the next start
//     pass       out  done & id_ok & ts_ok & !timeout
//     id_ok      out  captured ID equals EXPECTED_ID
//     ts_ok      out  captured timestamp equals EXPECTED_TS
//     timeout    out  a read stalled for TIMEOUT_CYCLES cycles
//     id_value   out  captured address-0 word
//     ts_value   out  captured address-1 word
//     state_dbg  out  current FSM state encoding
//
//   Parameters
//     EXPECTED_ID     expected word at address 0
//     EXPECTED_TS     expected word at address 1
//     READ_LATENCY    cycles from accepted read to valid readdata (0..3)
//     TIMEOUT_CYCLES  max consecutive waitrequest-high cycles per read (1..65535)
//     AUTO_START      1 = run the sequence once automatically after reset
// ---------------------------------------------------------------------------
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1483587485,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  sysid_check_ctrl_if.master      av,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout,
  output logic [31:0]             id_value,
  output logic [31:0]             ts_value,
  output logic [2:0]              state_dbg
);

  // FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ID   = 3'd1;
  localparam logic [2:0] S_WAIT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS   = 3'd3;
  localparam logic [2:0] S_WAIT_TS = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  // Last value of the latency counter before capture. Unused (WAIT states
  // unreachable) when READ_LATENCY is 0.
  localparam logic [1:0]  LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  logic [2:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] stall_inc;
  logic [1:0]  lat_cnt;
  logic        auto_pending;   // one-shot auto run, re-armed only by reset
  logic        stall_expire;   // this cycle is the TIMEOUT_CYCLES-th stall
  logic        accept;         // read handshake completes this cycle
  logic        lat_hit;        // readdata is valid this cycle (WAIT states)

  assign stall_inc    = stall_cnt + 16'd1;
  assign stall_expire = av.av_waitrequest && (stall_inc == TIMEOUT_LIMIT);
  assign accept       = !av.av_waitrequest;
  assign lat_hit      = (lat_cnt == LAT_LAST);

  // Status outputs decode straight from the registered state and flags.
  assign busy      = (state == S_RD_ID) || (state == S_WAIT_ID) ||
                     (state == S_RD_TS) || (state == S_WAIT_TS);
  assign done      = (state == S_DONE);
  assign pass      = done && id_ok && ts_ok && !timeout;
  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      auto_pending   <= AUTO_START;
      stall_cnt      <= 16'd0;
      lat_cnt        <= 2'd0;
      av.av_read     <= 1'b0;
      av.av_address  <= 1'b0;
      id_value       <= 32'd0;
      ts_value       <= 32'd0;
      id_ok          <= 1'b0;
      ts_ok          <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      case (state)
        // ------------------------------------------------------------------
        S_IDLE: begin
          if (start || auto_pending) begin
            auto_pending  <= 1'b0;
            id_value      <= 32'd0;
            ts_value      <= 32'd0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout       <= 1'b0;
            stall_cnt     <= 16'd0;
            av.av_read    <= 1'b1;
            av.av_address <= 1'b0;
            state         <= S_RD_ID;
          end
        end
        // ------------------------------------------------------------------
        S_RD_ID: begin
          if (stall_expire) begin
            // Give up: the ID word stays 0 and no timestamp read is issued.
            timeout       <= 1'b1;
            stall_cnt     <= stall_inc;
            av.av_read    <= 1'b0;
            av.av_address <= 1'b0;
            state         <= S_DONE;
          end else if (!accept) begin
            stall_cnt <= stall_inc;
          end else if (READ_LATENCY == 0) begin
            // Zero-latency slave: data is on the bus in the accept cycle.
            id_value      <= av.av_readdata;
            id_ok         <= (av.av_readdata == EXPECTED_ID);
            stall_cnt     <= 16'd0;
            av.av_address <= 1'b1;
            state         <= S_RD_TS;
          end else begin
            lat_cnt    <= 2'd0;
            av.av_read <= 1'b0;
            state      <= S_WAIT_ID;
          end
        end
        // ------------------------------------------------------------------
        S_WAIT_ID: begin
          if (lat_hit) begin
            id_value      <= av.av_readdata;
            id_ok         <= (av.av_readdata == EXPECTED_ID);
            stall_cnt     <= 16'd0;
            av.av_read    <= 1'b1;
            av.av_address <= 1'b1;
            state         <= S_RD_TS;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        // ------------------------------------------------------------------
        S_RD_TS: begin
          if (stall_expire) begin
            timeout       <= 1'b1;
            stall_cnt     <= stall_inc;
            av.av_read    <= 1'b0;
            av.av_address <= 1'b0;
            state         <= S_DONE;
          end else if (!accept) begin
            stall_cnt <= stall_inc;
          end else if (READ_LATENCY == 0) begin
            ts_value      <= av.av_readdata;
            ts_ok         <= (av.av_readdata == EXPECTED_TS);
            av.av_read    <= 1'b0;
            av.av_address <= 1'b0;
            state         <= S_DONE;
          end else begin
            lat_cnt       <= 2'd0;
            av.av_read    <= 1'b0;
            av.av_address <= 1'b0;
            state         <= S_WAIT_TS;
          end
        end
        // ------------------------------------------------------------------
        S_WAIT_TS: begin
          if (lat_hit) begin
            ts_value <= av.av_readdata;
            ts_ok    <= (av.av_readdata == EXPECTED_TS);
            state    <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        // ------------------------------------------------------------------
        S_DONE: begin
          // Results hold until a new start, which clears them and reruns.
          if (start) begin
            id_value      <= 32'd0;
            ts_value      <= 32'd0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout       <= 1'b0;
            stall_cnt     <= 16'd0;
            av.av_read    <= 1'b1;
            av.av_address <= 1'b0;
            state         <= S_RD_ID;
          end
        end
        // ------------------------------------------------------------------
        default: begin
          av.av_read    <= 1'b0;
          av.av_address <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sysid_check_ctrl
//   Directed bench for sysid_check_ctrl. Three instances cover the default
//   configuration (u_def), a short timeout (u_to, TIMEOUT_CYCLES=8) and a
//   latency-2 slave (u_lat). Each instance has its own reset/start and its
//   own small slave model.
// ---------------------------------------------------------------------------
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_TS     = 32'd1483587485;
  localparam logic [31:0] LAT_EXP_ID = 32'hC0DE_0042;
  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_WAIT_ID = 3'd2;
  localparam logic [2:0]  ST_RD_TS   = 3'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_def, rst_to, rst_lat;
  logic start_def, start_to, start_lat;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  // ---------------- DUT instances ----------------
  sysid_check_ctrl_if if_def ();
  sysid_check_ctrl_if if_to  ();
  sysid_check_ctrl_if if_lat ();

  logic        d_busy, d_done, d_pass, d_id_ok, d_ts_ok, d_timeout;
  logic [31:0] d_id_value, d_ts_value;
  logic [2:0]  d_state;
  logic        t_busy, t_done, t_pass, t_id_ok, t_ts_ok, t_timeout;
  logic [31:0] t_id_value, t_ts_value;
  logic [2:0]  t_state;
  logic        l_busy, l_done, l_pass, l_id_ok, l_ts_ok, l_timeout;
  logic [31:0] l_id_value, l_ts_value;
  logic [2:0]  l_state;

  sysid_check_ctrl u_def (
    .clock(clock), .reset(rst_def), .start(start_def), .av(if_def),
    .busy(d_busy), .done(d_done), .pass(d_pass), .id_ok(d_id_ok),
    .ts_ok(d_ts_ok), .timeout(d_timeout), .id_value(d_id_value),
    .ts_value(d_ts_value), .state_dbg(d_state)
  );

  sysid_check_ctrl #(.TIMEOUT_CYCLES(8)) u_to (
    .clock(clock), .reset(rst_to), .start(start_to), .av(if_to),
    .busy(t_busy), .done(t_done), .pass(t_pass), .id_ok(t_id_ok),
    .ts_ok(t_ts_ok), .timeout(t_timeout), .id_value(t_id_value),
    .ts_value(t_ts_value), .state_dbg(t_state)
  );

  sysid_check_ctrl #(.EXPECTED_ID(LAT_EXP_ID), .READ_LATENCY(2)) u_lat (
    .clock(clock), .reset(rst_lat), .start(start_lat), .av(if_lat),
    .busy(l_busy), .done(l_done), .pass(l_pass), .id_ok(l_id_ok),
    .ts_ok(l_ts_ok), .timeout(l_timeout), .id_value(l_id_value),
    .ts_value(l_ts_value), .state_dbg(l_state)
  );

  // ---------------- slave models ----------------
  // u_def: zero-latency slave, optional stall on the address-1 read.
  logic [31:0] def_id_word;
  int          def_stall_target;
  int          def_stall_seen;
  assign if_def.av_waitrequest = if_def.av_read && if_def.av_address &&
                                 (def_stall_seen < def_stall_target);
  assign if_def.av_readdata    = if_def.av_address ? EXP_TS : def_id_word;
  always @(posedge clock) begin
    if (!if_def.av_read)            def_stall_seen <= 0;
    else if (if_def.av_waitrequest) def_stall_seen <= def_stall_seen + 1;
  end

  // u_to: permanently stalled slave; records whether addr1 was ever read.
  logic to_saw_addr1 = 1'b0;
  assign if_to.av_waitrequest = 1'b1;
  assign if_to.av_readdata    = if_to.av_address ? EXP_TS : 32'h0000_1234;
  always @(posedge clock) begin
    if (if_to.av_read && if_to.av_address) to_saw_addr1 <= 1'b1;
  end

  // u_lat: data appears exactly 2 cycles after accept, garbage otherwise.
  logic lat_p1, lat_p2, lat_a1, lat_a2;
  assign if_lat.av_waitrequest = 1'b0;
  assign if_lat.av_readdata    = lat_p2 ? (lat_a2 ? EXP_TS : LAT_EXP_ID) : 32'hDEAD_BEEF;
  always @(posedge clock or posedge rst_lat) begin
    if (rst_lat) begin
      lat_p1 <= 1'b0; lat_p2 <= 1'b0; lat_a1 <= 1'b0; lat_a2 <= 1'b0;
    end else begin
      lat_p1 <= if_lat.av_read && !if_lat.av_waitrequest;
      lat_a1 <= if_lat.av_address;
      lat_p2 <= lat_p1;
      lat_a2 <= lat_a1;
    end
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic get_obs(input int which, output logic d, output logic rd, output logic ad);
    case (which)
      0:       begin d = d_done; rd = if_def.av_read; ad = if_def.av_address; end
      1:       begin d = t_done; rd = if_to.av_read;  ad = if_to.av_address;  end
      default: begin d = l_done; rd = if_lat.av_read; ad = if_lat.av_address; end
    endcase
  endtask

  // Scoreboard: expected (id, ts) pairs are queued before each run.
  task automatic sb_push(input logic [31:0] id, input logic [31:0] ts);
    exp_q.push_back(id);
    exp_q.push_back(ts);
  endtask

  task automatic sb_compare(input int which, input string tag);
    logic [31:0] e_id, e_ts, g_id, g_ts;
    if (exp_q.size() < 2) begin
      check_val({tag, ":sb_empty"}, 32'(exp_q.size()), 32'd2);
    end else begin
      e_id = exp_q.pop_front();
      e_ts = exp_q.pop_front();
      case (which)
        0:       begin g_id = d_id_value; g_ts = d_ts_value; end
        1:       begin g_id = t_id_value; g_ts = t_ts_value; end
        default: begin g_id = l_id_value; g_ts = l_ts_value; end
      endcase
      check_val({tag, ":id_value"}, g_id, e_id);
      check_val({tag, ":ts_value"}, g_ts, e_ts);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start(input int which);
    case (which)
      0:       start_def = 1'b1;
      1:       start_to  = 1'b1;
      default: start_lat = 1'b1;
    endcase
    tick(1);
    start_def = 1'b0;
    start_to  = 1'b0;
    start_lat = 1'b0;
  endtask

  // Counts edges until done, and per-address read-strobe cycles on the way.
  task automatic wait_done(input int which, input string tag, input int budget,
                           output int edges, output int rd0, output int rd1);
    logic d, rd, ad;
    edges = 0; rd0 = 0; rd1 = 0;
    get_obs(which, d, rd, ad);
    while (!d && edges < budget) begin
      if (rd) begin
        if (ad) rd1++;
        else    rd0++;
      end
      tick(1);
      edges++;
      get_obs(which, d, rd, ad);
    end
    check_val({tag, ":done_reached"}, 32'(d), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int e, r0, r1;

  initial begin
    rst_def = 1'b1; rst_to = 1'b1; rst_lat = 1'b1;
    start_def = 1'b0; start_to = 1'b0; start_lat = 1'b0;
    def_id_word = 32'd0;
    def_stall_target = 0;
    tick(2);

    // Reset state of every instance.
    check_val("rst_def_flags", {24'd0, d_busy, d_done, d_pass, d_id_ok, d_ts_ok, d_timeout,
                                if_def.av_read, if_def.av_address}, 32'd0);
    check_val("rst_def_vals", d_id_value | d_ts_value, 32'd0);
    check_val("rst_to_flags", {24'd0, t_busy, t_done, t_pass, t_id_ok, t_ts_ok, t_timeout,
                               if_to.av_read, if_to.av_address}, 32'd0);
    check_val("rst_lat_flags", {24'd0, l_busy, l_done, l_pass, l_id_ok, l_ts_ok, l_timeout,
                                if_lat.av_read, if_lat.av_address}, 32'd0);

    // 1: auto-run after reset, matching image; done on the 3rd edge.
    sb_push(32'd0, EXP_TS);
    rst_def = 1'b0;
    wait_done(0, "t1", 20, e, r0, r1);
    check_val("t1_edges", 32'(e), 32'd3);
    check_val("t1_rd_addr0", 32'(r0), 32'd1);
    check_val("t1_rd_addr1", 32'(r1), 32'd1);
    check_val("t1_pass", 32'(d_pass), 32'd1);
    check_val("t1_read_low", 32'(if_def.av_read), 32'd0);
    sb_compare(0, "t1");

    // 2: wrong ID word -> id_ok=0, ts_ok=1, pass=0.
    def_id_word = 32'h0000_0005;
    sb_push(32'h0000_0005, EXP_TS);
    pulse_start(0);
    check_val("t2_cleared", {29'd0, d_done, d_ts_ok, d_busy}, 32'd1);
    wait_done(0, "t2", 20, e, r0, r1);
    check_val("t2_edges", 32'(e), 32'd2);
    check_val("t2_flags", {29'd0, d_id_ok, d_ts_ok, d_pass}, 32'b010);
    sb_compare(0, "t2");

    // 3: five stall cycles on the addr1 read.
    def_id_word = 32'd0;
    def_stall_target = 5;
    sb_push(32'd0, EXP_TS);
    pulse_start(0);
    wait_done(0, "t3", 30, e, r0, r1);
    check_val("t3_edges", 32'(e), 32'd7);
    check_val("t3_rd_addr0", 32'(r0), 32'd1);
    check_val("t3_rd_addr1", 32'(r1), 32'd6);
    check_val("t3_pass", 32'(d_pass), 32'd1);
    sb_compare(0, "t3");

    // 4: TIMEOUT_CYCLES=8, slave stuck on addr0.
    sb_push(32'd0, 32'd0);
    rst_to = 1'b0;
    wait_done(1, "t4", 40, e, r0, r1);
    check_val("t4_edges", 32'(e), 32'd9);
    check_val("t4_rd_addr0", 32'(r0), 32'd8);
    check_val("t4_flags", {27'd0, t_timeout, t_pass, t_id_ok, t_busy, if_to.av_read}, 32'b10000);
    check_val("t4_no_addr1", 32'(to_saw_addr1), 32'd0);
    sb_compare(1, "t4");

    // 5: READ_LATENCY=2, non-zero expected ID.
    sb_push(LAT_EXP_ID, EXP_TS);
    rst_lat = 1'b0;
    wait_done(2, "t5", 40, e, r0, r1);
    check_val("t5_edges", 32'(e), 32'd7);
    check_val("t5_rd_addr0", 32'(r0), 32'd1);
    check_val("t5_rd_addr1", 32'(r1), 32'd1);
    check_val("t5_pass", 32'(l_pass), 32'd1);
    sb_compare(2, "t5");

    // 6a: start pulsed while in RD_TS is ignored.
    sb_push(LAT_EXP_ID, EXP_TS);
    pulse_start(2);
    tick(3);
    check_val("t6a_in_rd_ts", 32'(l_state), 32'(ST_RD_TS));
    pulse_start(2);
    wait_done(2, "t6a", 20, e, r0, r1);
    check_val("t6a_edges", 32'(e), 32'd2);
    check_val("t6a_no_restart", 32'(r0 + r1), 32'd0);
    check_val("t6a_pass", 32'(l_pass), 32'd1);
    sb_compare(2, "t6a");

    // 6b: reset in WAIT_ID clears everything at once, then auto-run passes.
    pulse_start(2);
    tick(1);
    check_val("t6b_in_wait_id", 32'(l_state), 32'(ST_WAIT_ID));
    rst_lat = 1'b1;
    #1;
    check_val("t6b_rst_flags", {24'd0, l_busy, l_done, l_pass, l_id_ok, l_ts_ok, l_timeout,
                                if_lat.av_read, if_lat.av_address}, 32'd0);
    check_val("t6b_rst_vals", l_id_value | l_ts_value, 32'd0);
    check_val("t6b_rst_state", 32'(l_state), 32'(ST_IDLE));
    tick(1);
    rst_lat = 1'b0;
    sb_push(LAT_EXP_ID, EXP_TS);
    wait_done(2, "t6b", 40, e, r0, r1);
    check_val("t6b_edges", 32'(e), 32'd7);
    check_val("t6b_pass", 32'(l_pass), 32'd1);
    sb_compare(2, "t6b");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
